// File: rtl/irq_mux_pkg.sv
// irq_mux shared constants: register offsets, empty-vector code
// and the lowest-set-bit priority helper used by VECTOR.
package irq_mux_pkg;

  localparam logic [2:0] OFS_STATUS = 3'd0;
  localparam logic [2:0] OFS_ENABLE = 3'd1;
  localparam logic [2:0] OFS_MODE   = 3'd2;
  localparam logic [2:0] OFS_CLEAR  = 3'd3;
  localparam logic [2:0] OFS_VECTOR = 3'd4;
  localparam logic [2:0] OFS_RAW    = 3'd5;

  localparam logic [7:0] VEC_NONE = 8'h80;

  function automatic logic [7:0] lowest_set(
    input logic [7:0] v
  );
    logic [7:0] r;
    r = VEC_NONE;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = i[7:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/irq_chan.sv
// One request channel: 2-flop sync, edge detect, PEND flop.
// Ports: clk, rst_n, src, mode, clr in; raw (s2), pend out.
module irq_chan
  import irq_mux_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic src,
  input  logic mode,
  input  logic clr,
  output logic raw,
  output logic pend
);

  logic       s1;
  logic       s2;
  logic       s3;
  logic [2:0] live;
  logic       rise;

  // live[2] marks s3 as holding a real post-reset sample, so a
  // source held high through reset is not taken as an edge.
  assign rise = s2 & ~s3 & live[2];
  assign raw  = s2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      live <= '0;
      pend <= 1'b0;
    end else begin
      s1   <= src;
      s2   <= s1;
      s3   <= s2;
      live <= {live[1:0], 1'b1};
      if (mode) pend <= s2;
      else      pend <= (pend & ~clr) | rise;
    end
  end

endmodule

// File: rtl/irq_mux.sv
// irq_mux: NCH-channel interrupt concentrator, 8-byte window at
// BASE. Bus: AD/DO/WE/RDY in, DI/SEL out; SRC in; IRQ/NMI out.
// Define IRQ_MUX_NMI_EN to make channel NCH-1 the NMI source.
module irq_mux
  import irq_mux_pkg::*;
#(
  parameter int          NCH  = 8,
  parameter logic [15:0] BASE = 16'hFE00
) (
  input  logic           clk,
  input  logic           RST_N,
  input  logic [15:0]    AD,
  input  logic [7:0]     DO,
  input  logic           WE,
  input  logic           RDY,
  output logic [7:0]     DI,
  output logic           SEL,
  input  logic [NCH-1:0] SRC,
  output logic           IRQ,
  output logic           NMI
);

  localparam logic [7:0] CHM = 8'hFF >> (8 - NCH);
`ifdef IRQ_MUX_NMI_EN
  localparam logic [7:0] NMIB = 8'(1 << (NCH - 1));
  localparam logic [7:0] WMASK = CHM & ~NMIB;
`else
  localparam logic [7:0] WMASK = CHM;
`endif

  logic [7:0] enable;
  logic [7:0] mode_r;
  logic [7:0] pend;
  logic [7:0] raw;
  logic [7:0] active;
  logic [7:0] clr;
  logic [7:0] rdata;
  logic [2:0] ofs;
  logic       hit;
  logic       wr;

  assign hit = (AD[15:3] == BASE[15:3]);
  assign ofs = AD[2:0];
  assign wr  = hit & WE & RDY;
  assign clr = (wr && ofs == OFS_CLEAR) ? DO : 8'h00;

  for (genvar i = 0; i < 8; i++) begin : g_ch
    if (i < NCH) begin : g_on
      irq_chan u_chan (
        .clk  (clk),
        .rst_n(RST_N),
        .src  (SRC[i]),
        .mode (mode_r[i]),
        .clr  (clr[i]),
        .raw  (raw[i]),
        .pend (pend[i])
      );
    end else begin : g_off
      assign raw[i]  = 1'b0;
      assign pend[i] = 1'b0;
    end
  end

  // NMI channel has ENABLE forced 0, so it drops out here.
  assign active = pend & enable;
  assign IRQ    = |active;

`ifdef IRQ_MUX_NMI_EN
  assign NMI = pend[NCH-1];
`else
  assign NMI = 1'b0;
`endif

  always_comb begin
    rdata = 8'h00;
    unique case (ofs)
      OFS_STATUS: rdata = pend;
      OFS_ENABLE: rdata = enable;
      OFS_MODE:   rdata = mode_r;
      OFS_VECTOR: rdata = lowest_set(active);
      OFS_RAW:    rdata = raw;
      default:    rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!RST_N) begin
      enable <= 8'h00;
      mode_r <= 8'h00;
      DI     <= 8'h00;
      SEL    <= 1'b0;
    end else if (RDY) begin
      if (wr && ofs == OFS_ENABLE) enable <= DO & WMASK;
      if (wr && ofs == OFS_MODE)   mode_r <= DO & WMASK;
      DI  <= (hit & ~WE) ? rdata : 8'h00;
      SEL <= hit & ~WE;
    end
  end

endmodule

// File: tb/tb_irq_mux.sv
// Scoreboard bench for irq_mux: reads push expected DI, a monitor
// pops on SEL; IRQ/NMI levels are checked inline.
module tb_irq_mux;

  localparam logic [15:0] BASE = 16'hFE00;

  logic        clk = 1'b0;
  logic        RST_N;
  logic [15:0] AD;
  logic [7:0]  DO;
  logic        WE;
  logic        RDY;
  logic [7:0]  DI;
  logic        SEL;
  logic [7:0]  SRC;
  logic        IRQ;
  logic        NMI;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  string      nam_q[$];
  logic       rdy_q = 1'b0;

  irq_mux #(.NCH(8), .BASE(BASE)) dut (
    .clk  (clk),
    .RST_N(RST_N),
    .AD   (AD),
    .DO   (DO),
    .WE   (WE),
    .RDY  (RDY),
    .DI   (DI),
    .SEL  (SEL),
    .SRC  (SRC),
    .IRQ  (IRQ),
    .NMI  (NMI)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rdy_q <= RDY;

  always @(negedge clk) begin
    if (SEL && rdy_q) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_read DI=%h (no read pending)", DI);
      end else begin
        logic [7:0] e;
        string      n;
        e = exp_q.pop_front();
        n = nam_q.pop_front();
        if (DI !== e) begin
          failures++;
          $display("FAIL %s DI=%h expected=%h", n, DI, e);
        end
      end
    end
  end

  task automatic chk(input string n, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", n, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] o, input logic [7:0] d);
    AD  = {BASE[15:3], o};
    DO  = d;
    WE  = 1'b1;
    RDY = 1'b1;
    @(negedge clk);
    WE  = 1'b0;
    AD  = 16'h0000;
  endtask

  task automatic rd(input string n, input logic [2:0] o,
                    input logic [7:0] e);
    AD  = {BASE[15:3], o};
    WE  = 1'b0;
    RDY = 1'b1;
    exp_q.push_back(e);
    nam_q.push_back(n);
    @(negedge clk);
    AD  = 16'h0000;
  endtask

  task automatic pulse(input logic [7:0] m);
    SRC = m;
    @(negedge clk);
    SRC = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    RST_N = 1'b0;
    AD    = 16'h0000;
    DO    = 8'h00;
    WE    = 1'b0;
    RDY   = 1'b1;
    SRC   = 8'hFF;
    repeat (2) @(negedge clk);
    chk("rst_irq", {7'b0, IRQ}, 8'h00);
    chk("rst_nmi", {7'b0, NMI}, 8'h00);
    chk("rst_sel", {7'b0, SEL}, 8'h00);
    chk("rst_di", DI, 8'h00);
    RST_N = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_irq_after", {7'b0, IRQ}, 8'h00);
    rd("rst_status", 3'd0, 8'h00);
    rd("rst_enable", 3'd1, 8'h00);
    rd("rst_vector", 3'd4, 8'h80);
    rd("rst_raw", 3'd5, 8'hFF);
    SRC = 8'h00;
    repeat (4) @(negedge clk);
    rd("rst_status_low", 3'd0, 8'h00);

    // edge latch, 3-edge latency, clear
    wr(3'd1, 8'h04);
    pulse(8'h04);
    chk("edge_lat1", {7'b0, IRQ}, 8'h00);
    @(negedge clk);
    chk("edge_lat2", {7'b0, IRQ}, 8'h00);
    @(negedge clk);
    chk("edge_lat3", {7'b0, IRQ}, 8'h01);
    rd("edge_vector", 3'd4, 8'h02);
    wr(3'd3, 8'h04);
    chk("edge_clr_irq", {7'b0, IRQ}, 8'h00);
    rd("edge_clr_status", 3'd0, 8'h00);

    // priority and masking
    wr(3'd1, 8'h08);
    pulse(8'h0A);
    repeat (3) @(negedge clk);
    rd("pri_status", 3'd0, 8'h0A);
    rd("pri_vec_3", 3'd4, 8'h03);
    wr(3'd1, 8'h0A);
    rd("pri_vec_1", 3'd4, 8'h01);
    wr(3'd3, 8'h0A);
    rd("pri_vec_none", 3'd4, 8'h80);

    // level mode
    wr(3'd2, 8'h01);
    wr(3'd1, 8'h01);
    SRC = 8'h01;
    repeat (3) @(negedge clk);
    chk("lvl_irq_on", {7'b0, IRQ}, 8'h01);
    wr(3'd3, 8'h01);
    chk("lvl_clr_noeff", {7'b0, IRQ}, 8'h01);
    rd("lvl_mode", 3'd2, 8'h01);
    SRC = 8'h00;
    repeat (2) @(negedge clk);
    chk("lvl_irq_hold", {7'b0, IRQ}, 8'h01);
    @(negedge clk);
    chk("lvl_irq_off", {7'b0, IRQ}, 8'h00);
    wr(3'd2, 8'h00);

    // set beats clear in the same cycle
    wr(3'd1, 8'h20);
    SRC = 8'h20;
    @(negedge clk);
    SRC = 8'h00;
    @(negedge clk);
    wr(3'd3, 8'h20);
    chk("coll_irq", {7'b0, IRQ}, 8'h01);
    rd("coll_status", 3'd0, 8'h20);
    wr(3'd3, 8'h20);
    rd("coll_cleared", 3'd0, 8'h00);

    // RDY=0 freezes writes and read outputs
    wr(3'd1, 8'h5A);
    AD  = {BASE[15:3], 3'd1};
    WE  = 1'b0;
    RDY = 1'b1;
    exp_q.push_back(8'h5A);
    nam_q.push_back("rdy_read");
    @(negedge clk);
    AD  = {BASE[15:3], 3'd1};
    DO  = 8'hFF;
    WE  = 1'b1;
    RDY = 1'b0;
    @(negedge clk);
    chk("rdy_sel_hold1", {7'b0, SEL}, 8'h01);
    chk("rdy_di_hold1", DI, 8'h5A);
    @(negedge clk);
    chk("rdy_sel_hold2", {7'b0, SEL}, 8'h01);
    chk("rdy_di_hold2", DI, 8'h5A);
    WE  = 1'b0;
    RDY = 1'b1;
    AD  = 16'h0000;
    @(negedge clk);
    rd("rdy_en_kept", 3'd1, 8'h5A);

    // misc map entries and decode
    rd("clear_reads0", 3'd3, 8'h00);
    wr(3'd6, 8'hFF);
    rd("ofs6_reads0", 3'd6, 8'h00);
    AD = BASE + 16'h0008;
    WE = 1'b0;
    @(negedge clk);
    chk("miss_sel", {7'b0, SEL}, 8'h00);
    chk("miss_di", DI, 8'h00);
    AD = 16'h0000;

`ifdef IRQ_MUX_NMI_EN
    wr(3'd1, 8'hFF);
    rd("nmi_en_mask", 3'd1, 8'h7F);
    pulse(8'h80);
    repeat (2) @(negedge clk);
    chk("nmi_on", {7'b0, NMI}, 8'h01);
    chk("nmi_irq_off", {7'b0, IRQ}, 8'h00);
    rd("nmi_vector", 3'd4, 8'h80);
    rd("nmi_status", 3'd0, 8'h80);
    wr(3'd3, 8'h80);
    chk("nmi_clr", {7'b0, NMI}, 8'h00);
    pulse(8'h80);
    repeat (2) @(negedge clk);
    chk("nmi_again", {7'b0, NMI}, 8'h01);
`else
    wr(3'd1, 8'hFF);
    rd("en_full", 3'd1, 8'hFF);
    pulse(8'h80);
    repeat (2) @(negedge clk);
    chk("ch7_irq", {7'b0, IRQ}, 8'h01);
    chk("ch7_nmi0", {7'b0, NMI}, 8'h00);
    rd("ch7_vector", 3'd4, 8'h07);
`endif

    for (int i = 0; i < 10 && exp_q.size() != 0; i++)
      @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL read_drain pending=%0d expected=0",
               exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
